// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  wire axb, na, na_b, n_axb, prop;

  xor g_x0 (axb, a, b);
  xor g_x1 (d, axb, bi);
  not g_n0 (na, a);
  and g_a0 (na_b, na, b);
  // Incoming borrow propagates only when a and b are equal.
  not g_n1 (n_axb, axb);
  and g_a1 (prop, n_axb, bi);
  or  g_o0 (bo, na_b, prop);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one full-subtractor cell plus a borrow flop;
// start/busy operand handshake and valid/ack result handshake.
import serial_subtractor_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_sign, b_sign;
  logic             d, bo;
  logic [WIDTH-1:0] diff_nxt;

  full_subtractor u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  // Flags on the final edge look at the diff being written, not the stale one.
  assign diff_nxt = {d, diff[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff   <= diff_nxt;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= DONE;
            valid      <= 1'b1;
            borrow_out <= bo;
            overflow   <= (a_sign != b_sign) && (diff_nxt[WIDTH-1] != a_sign);
            zero       <= (diff_nxt == '0);
          end
        end
        DONE: begin
          if (ack) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench: stimulus pushes reference results, a negedge monitor checks each DONE.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, bin, ack;
  logic [W-1:0] a, b;
  logic         busy, valid, borrow_out, overflow, zero;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin), .ack(ack),
    .busy(busy), .valid(valid), .diff(diff), .borrow_out(borrow_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo, ov, z;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, input int acc);
    exp_t e;
    int   ur, sr, sa, sb;
    ur     = int'(ma) - int'(mb) - int'(mbin);
    sa     = $signed(ma);
    sb     = $signed(mb);
    sr     = sa - sb - int'(mbin);
    e.diff = ur[W-1:0];
    e.bo   = (ur < 0);
    e.ov   = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    e.z    = (e.diff == '0);
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: checks result on valid rising, then stability while held.
  initial begin
    logic         pv;
    logic [W-1:0] held;
    exp_t         e;
    pv   = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (valid && !pv) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("latency", 32'(cyc - e.acc), 32'(W));
          check("diff", 32'(diff), 32'(e.diff));
          check("borrow_out", 32'(borrow_out), 32'(e.bo));
          check("overflow", 32'(overflow), 32'(e.ov));
          check("zero", 32'(zero), 32'(e.z));
          check("busy_in_done", 32'(busy), 32'd1);
        end
        held = diff;
      end else if (valid && pv) begin
        check("diff_stable", 32'(diff), 32'(held));
      end
      pv = valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ibin, input bit push);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    step();
    start = 1'b0;
    if (push) sbq.push_back(model(ia, ib, ibin, cyc));
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < W + 4 && !ok; i++) begin
      if (valid) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      check("valid_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input int hold, input bit noise, input bit start_with_ack);
    issue(ia, ib, ibin, 1'b1);
    if (noise) begin
      step();
      start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      step();
      start = 1'b0;
    end
    wait_valid();
    if (noise) begin
      start = 1'b1; a = W'($urandom); b = W'($urandom);
      step();
      start = 1'b0;
    end
    repeat (hold) step();
    ack = 1'b1;
    start = start_with_ack;
    step();
    ack = 1'b0;
    start = 1'b0;
    check("valid_after_ack", 32'(valid), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
    if (start_with_ack) begin
      step();
      step();
      check("no_op_from_ack_start", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; bin = 1'b0; a = '0; b = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({borrow_out, overflow, zero}), 32'd0);
    rst = 1'b0;
    step();

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);

    // Abort mid-shift: no result may appear for this operation.
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_flags", 32'({borrow_out, overflow, zero}), 32'd0);
    run_op(8'h0A, 8'h0A, 1'b0, 0, 1'b0, 1'b0);

    run_op(8'h3C, 8'h1E, 1'b0, 5, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));

    step();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
